// File: rtl/wb_ext_queue.sv
// Queued Wishbone classic master: host commands pass through a FIFO, run in order
// with byte-lane steering, misalignment checks and a bus timeout, one response each.
module wb_ext_queue #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           cmd_valid_i,
  output logic                           cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0]          cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]          cmd_data_i,
  input  logic [1:0]                     cmd_size_i,
  input  logic                           cmd_we_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [DATA_WIDTH-1:0]          rsp_data_o,
  output logic                           rsp_err_o,
  output logic                           rsp_timeout_o,
  output logic [$clog2(CMD_DEPTH+1)-1:0] pending_o,
  output logic [ADDR_WIDTH-1:0]          wb_addr_o,
  output logic [DATA_WIDTH-1:0]          wb_data_o,
  output logic [3:0]                     wb_sel_o,
  output logic                           wb_we_o,
  output logic                           wb_stb_o,
  output logic                           wb_cyc_o,
  input  logic                           wb_ack_i,
  input  logic [DATA_WIDTH-1:0]          wb_data_i
);

  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int CNT_W = $clog2(CMD_DEPTH + 1);
  localparam int TMR_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(CMD_DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            size;
    logic                  we;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_BUS, S_RESP} state_t;

  state_t state_q, state_d;

  cmd_t             fifo_mem [CMD_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push, pop;

  cmd_t                  cmd_q;
  logic [TMR_W-1:0]      timer_q;
  logic [DATA_WIDTH-1:0] res_data_q;
  logic                  res_err_q, res_to_q;

  logic                  slot_free, misaligned;
  logic                  go_bus, chk_err, bus_done, bus_to;
  logic [3:0]            lane_sel;
  logic [DATA_WIDTH-1:0] lane_data, rd_shifted, rd_data;

  // Ready reflects occupancy only, so a full FIFO refuses even when a pop coincides.
  assign cmd_ready_o = (count_q != CNT_FULL);
  assign push        = cmd_valid_i && cmd_ready_o;
  assign pending_o   = count_q;
  assign slot_free   = !rsp_valid_o || rsp_ready_i;

  // NOTE: the command storage has no reset; the pointers and count alone define validity.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= '{addr: cmd_addr_i, data: cmd_data_i,
                                      size: cmd_size_i, we: cmd_we_i};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    misaligned = 1'b0;
    case (cmd_q.size)
      2'd1:    misaligned = cmd_q.addr[0];
      2'd2:    misaligned = (cmd_q.addr[1:0] != 2'b00);
      2'd3:    misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    lane_sel  = 4'b1111;
    lane_data = cmd_q.data;
    rd_shifted = wb_data_i >> {cmd_q.addr[1:0], 3'b000};
    rd_data    = rd_shifted;
    case (cmd_q.size)
      2'd0: begin
        lane_sel  = 4'b0001 << cmd_q.addr[1:0];
        lane_data = {4{cmd_q.data[7:0]}};
        rd_data   = {24'b0, rd_shifted[7:0]};
      end
      2'd1: begin
        lane_sel  = 4'b0011 << {cmd_q.addr[1], 1'b0};
        lane_data = {2{cmd_q.data[15:0]}};
        rd_data   = {16'b0, rd_shifted[15:0]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    go_bus   = 1'b0;
    chk_err  = 1'b0;
    bus_done = 1'b0;
    bus_to   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((count_q != '0) && slot_free) begin
          pop     = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (misaligned) begin
          chk_err = 1'b1;
          state_d = S_RESP;
        end else begin
          go_bus  = 1'b1;
          state_d = S_BUS;
        end
      end
      S_BUS: begin
        // An ack in the timeout cycle still completes normally.
        if (wb_ack_i) begin
          bus_done = 1'b1;
          state_d  = S_RESP;
        end else if ((TIMEOUT_CYCLES != 0) && (timer_q == TMR_LIMIT)) begin
          bus_to  = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cmd_q         <= '0;
      timer_q       <= '0;
      res_data_q    <= '0;
      res_err_q     <= 1'b0;
      res_to_q      <= 1'b0;
      wb_addr_o     <= '0;
      wb_data_o     <= '0;
      wb_sel_o      <= '0;
      wb_we_o       <= 1'b0;
      wb_stb_o      <= 1'b0;
      wb_cyc_o      <= 1'b0;
      rsp_valid_o   <= 1'b0;
      rsp_data_o    <= '0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
    end else begin
      if (pop) cmd_q <= fifo_mem[rd_ptr_q];

      if (chk_err) begin
        res_data_q <= '0;
        res_err_q  <= 1'b1;
        res_to_q   <= 1'b0;
      end

      if (go_bus) begin
        wb_addr_o <= {cmd_q.addr[ADDR_WIDTH-1:2], 2'b00};
        wb_we_o   <= cmd_q.we;
        wb_sel_o  <= lane_sel;
        wb_data_o <= lane_data;
        wb_cyc_o  <= 1'b1;
        wb_stb_o  <= 1'b1;
        timer_q   <= TMR_W'(1);
      end else if (state_q == S_BUS) begin
        timer_q <= timer_q + 1'b1;
      end

      if (bus_done || bus_to) begin
        wb_cyc_o <= 1'b0;
        wb_stb_o <= 1'b0;
        wb_we_o  <= 1'b0;
      end
      if (bus_done) begin
        res_data_q <= cmd_q.we ? '0 : rd_data;
        res_err_q  <= 1'b0;
        res_to_q   <= 1'b0;
      end
      if (bus_to) begin
        res_data_q <= '0;
        res_err_q  <= 1'b1;
        res_to_q   <= 1'b1;
      end

      if (state_q == S_RESP) begin
        rsp_valid_o   <= 1'b1;
        rsp_data_o    <= res_data_q;
        rsp_err_o     <= res_err_q;
        rsp_timeout_o <= res_to_q;
      end else if (rsp_ready_i) begin
        rsp_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_ext_queue.sv
// Directed bench for wb_ext_queue: table of single commands against a small
// Wishbone RAM slave, plus queued-error, timeout, back-pressure and reset sequences.
module tb_wb_ext_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [31:0] cmd_addr = '0, cmd_data = '0;
  logic [1:0]  cmd_size = '0;
  logic        cmd_we = 1'b0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err, rsp_timeout;
  logic [2:0]  pending;
  logic [31:0] wb_addr, wb_wdata, wb_rdata;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_stb, wb_cyc, wb_ack;

  int total = 0;
  int bad   = 0;

  wb_ext_queue #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .CMD_DEPTH(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data), .cmd_size_i(cmd_size), .cmd_we_i(cmd_we),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout),
    .pending_o(pending),
    .wb_addr_o(wb_addr), .wb_data_o(wb_wdata), .wb_sel_o(wb_sel),
    .wb_we_o(wb_we), .wb_stb_o(wb_stb), .wb_cyc_o(wb_cyc),
    .wb_ack_i(wb_ack), .wb_data_i(wb_rdata)
  );

  always #5 clk = ~clk;

  // Slave RAM: acks one cycle after a strobe below 0x100; higher addresses never ack.
  logic [31:0] ram [64];
  initial begin
    for (int i = 0; i < 64; i++) ram[i] = '0;
    ram[4] = 32'hDEADBEEF;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ack   <= 1'b0;
      wb_rdata <= '0;
    end else begin
      wb_ack <= 1'b0;
      if (wb_cyc && wb_stb && !wb_ack && (wb_addr < 32'h100)) begin
        wb_ack   <= 1'b1;
        wb_rdata <= ram[wb_addr[7:2]];
        if (wb_we)
          for (int b = 0; b < 4; b++)
            if (wb_sel[b]) ram[wb_addr[7:2]][8*b +: 8] <= wb_wdata[8*b +: 8];
      end
    end
  end

  int          cyc_cnt = 0;
  logic [3:0]  mon_sel;
  logic [31:0] mon_addr, mon_wdata;
  always @(negedge clk) begin
    if (wb_cyc) begin
      cyc_cnt   = cyc_cnt + 1;
      mon_sel   = wb_sel;
      mon_addr  = wb_addr;
      mon_wdata = wb_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] s, input logic we);
    int n = 0;
    @(negedge clk);
    cmd_addr = a; cmd_data = d; cmd_size = s; cmd_we = we; cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("push_accept", {31'b0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic [31:0] d, output logic e, output logic t);
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rsp_arrive", {31'b0, rsp_valid}, 32'd1);
    d = rsp_data; e = rsp_err; t = rsp_timeout;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic        we;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [3:0]  exp_sel;
    logic [31:0] exp_wdata;
    logic [31:0] exp_waddr;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[14];

  logic [31:0] d;
  logic        e, t;
  int          seen;

  initial begin
    vecs[0]  = '{32'h10, 32'h0,        2'd2, 1'b0, 32'hDEADBEEF, 1'b0, 4'b1111, 32'h0,        32'h10, 2};
    vecs[1]  = '{32'h10, 32'h0,        2'd2, 1'b1, 32'h0,        1'b0, 4'b1111, 32'h0,        32'h10, 2};
    vecs[2]  = '{32'h13, 32'h123456A5, 2'd0, 1'b1, 32'h0,        1'b0, 4'b1000, 32'hA5A5A5A5, 32'h10, 2};
    vecs[3]  = '{32'h10, 32'h0,        2'd2, 1'b0, 32'hA5000000, 1'b0, 4'b1111, 32'h0,        32'h10, 2};
    vecs[4]  = '{32'h13, 32'h0,        2'd0, 1'b0, 32'h000000A5, 1'b0, 4'b1000, 32'h0,        32'h10, 2};
    vecs[5]  = '{32'h16, 32'hABCD1234, 2'd1, 1'b1, 32'h0,        1'b0, 4'b1100, 32'h12341234, 32'h14, 2};
    vecs[6]  = '{32'h15, 32'h0000007E, 2'd0, 1'b1, 32'h0,        1'b0, 4'b0010, 32'h7E7E7E7E, 32'h14, 2};
    vecs[7]  = '{32'h16, 32'h0,        2'd1, 1'b0, 32'h00001234, 1'b0, 4'b1100, 32'h0,        32'h14, 2};
    vecs[8]  = '{32'h14, 32'h0,        2'd1, 1'b0, 32'h00007E00, 1'b0, 4'b0011, 32'h0,        32'h14, 2};
    vecs[9]  = '{32'h14, 32'h0,        2'd2, 1'b0, 32'h12347E00, 1'b0, 4'b1111, 32'h0,        32'h14, 2};
    vecs[10] = '{32'h12, 32'h0,        2'd0, 1'b0, 32'h00000000, 1'b0, 4'b0100, 32'h0,        32'h10, 2};
    vecs[11] = '{32'h11, 32'h0000FFFF, 2'd1, 1'b1, 32'h0,        1'b1, 4'b0000, 32'h0,        32'h0,  0};
    vecs[12] = '{32'h12, 32'h0,        2'd2, 1'b0, 32'h0,        1'b1, 4'b0000, 32'h0,        32'h0,  0};
    vecs[13] = '{32'h10, 32'h0,        2'd3, 1'b0, 32'h0,        1'b1, 4'b0000, 32'h0,        32'h0,  0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cyc",     {31'b0, wb_cyc},    32'd0);
    check("rst_stb",     {31'b0, wb_stb},    32'd0);
    check("rst_rvalid",  {31'b0, rsp_valid}, 32'd0);
    check("rst_rdata",   rsp_data,           32'd0);
    check("rst_pending", {29'b0, pending},   32'd0);
    check("rst_wbaddr",  wb_addr,            32'd0);
    check("rst_sel",     {28'b0, wb_sel},    32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'b0, cmd_ready}, 32'd1);

    // Single commands from the table
    for (int i = 0; i < 14; i++) begin
      cyc_cnt = 0;
      push(vecs[i].addr, vecs[i].data, vecs[i].size, vecs[i].we);
      get_rsp(d, e, t);
      check($sformatf("v%0d_data", i), d, vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i),  {31'b0, e}, {31'b0, vecs[i].exp_err});
      check($sformatf("v%0d_to", i),   {31'b0, t}, 32'd0);
      check($sformatf("v%0d_cyc", i),  cyc_cnt, vecs[i].exp_cyc);
      if (vecs[i].exp_cyc != 0) begin
        check($sformatf("v%0d_sel", i),   {28'b0, mon_sel}, {28'b0, vecs[i].exp_sel});
        check($sformatf("v%0d_waddr", i), mon_addr, vecs[i].exp_waddr);
        if (vecs[i].we) check($sformatf("v%0d_wdata", i), mon_wdata, vecs[i].exp_wdata);
      end
    end

    // Three queued illegal commands: errors in order, bus untouched
    cyc_cnt = 0;
    push(32'h11, 32'h0, 2'd1, 1'b1);
    push(32'h12, 32'h0, 2'd2, 1'b0);
    push(32'h10, 32'h0, 2'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      get_rsp(d, e, t);
      check($sformatf("qerr%0d_err", i),  {31'b0, e}, 32'd1);
      check($sformatf("qerr%0d_to", i),   {31'b0, t}, 32'd0);
      check($sformatf("qerr%0d_data", i), d, 32'd0);
    end
    check("qerr_cyc", cyc_cnt, 32'd0);

    // Timeout on a silent slave, then a normal command behind it
    cyc_cnt = 0;
    push(32'h1000, 32'h0, 2'd2, 1'b0);
    push(32'h10,   32'h0, 2'd2, 1'b0);
    get_rsp(d, e, t);
    check("to_err",  {31'b0, e}, 32'd1);
    check("to_flag", {31'b0, t}, 32'd1);
    check("to_data", d, 32'd0);
    check("to_cyc",  cyc_cnt, 32'd8);
    cyc_cnt = 0;
    get_rsp(d, e, t);
    check("after_to_data", d, 32'hA5000000);
    check("after_to_err",  {31'b0, e}, 32'd0);
    check("after_to_cyc",  cyc_cnt, 32'd2);

    // Back-pressure: host holds rsp_ready low
    push(32'h10, 32'h0, 2'd2, 1'b0);
    check("bp_pend1", {29'b0, pending}, 32'd1);
    push(32'h14, 32'h0, 2'd2, 1'b0);
    check("bp_pend_pushpop", {29'b0, pending}, 32'd1);
    push(32'h15, 32'h0, 2'd0, 1'b0);
    push(32'h16, 32'h0, 2'd1, 1'b0);
    push(32'h11, 32'h0, 2'd2, 1'b0);
    check("bp_pend4", {29'b0, pending}, 32'd4);
    @(negedge clk);
    cmd_addr = 32'h10; cmd_size = 2'd2; cmd_we = 1'b0; cmd_valid = 1'b1;
    repeat (5) @(negedge clk);
    check("bp_full_ready", {31'b0, cmd_ready}, 32'd0);
    check("bp_full_pend",  {29'b0, pending},   32'd4);
    cmd_valid = 1'b0;
    check("bp_hold_valid", {31'b0, rsp_valid}, 32'd1);
    check("bp_hold_data",  rsp_data, 32'hA5000000);
    repeat (3) @(negedge clk);
    check("bp_hold_valid2", {31'b0, rsp_valid}, 32'd1);
    check("bp_hold_data2",  rsp_data, 32'hA5000000);
    get_rsp(d, e, t);
    check("bp0_data", d, 32'hA5000000);
    get_rsp(d, e, t);
    check("bp1_data", d, 32'h12347E00);
    get_rsp(d, e, t);
    check("bp2_data", d, 32'h0000007E);
    get_rsp(d, e, t);
    check("bp3_data", d, 32'h00001234);
    get_rsp(d, e, t);
    check("bp4_err",  {31'b0, e}, 32'd1);
    check("bp4_data", d, 32'd0);
    check("bp_drained", {29'b0, pending}, 32'd0);

    // Reset in the middle of a bus cycle with a command still queued
    push(32'h1000, 32'h0, 2'd2, 1'b0);
    push(32'h10,   32'h0, 2'd2, 1'b0);
    seen = 0;
    while (!wb_cyc && seen < 50) begin
      @(negedge clk);
      seen++;
    end
    check("mid_cyc_seen", {31'b0, wb_cyc}, 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_cyc",    {31'b0, wb_cyc},    32'd0);
    check("mid_rst_stb",    {31'b0, wb_stb},    32'd0);
    check("mid_rst_rvalid", {31'b0, rsp_valid}, 32'd0);
    check("mid_rst_pend",   {29'b0, pending},   32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc_cnt = 0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("post_rst_stale", seen, 32'd0);
    check("post_rst_cyc",   cyc_cnt, 32'd0);
    check("post_rst_ready", {31'b0, cmd_ready}, 32'd1);
    push(32'h10, 32'h0, 2'd2, 1'b0);
    get_rsp(d, e, t);
    check("post_rst_data", d, 32'hA5000000);
    check("post_rst_err",  {31'b0, e}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
